score_pulse_gen: RTL and testbench
==================================

SCORE_PULSE_GEN -- requirements
Module: score_pulse_gen

Interface
REQ-001 SHALL have parameter PULSE_HIGH_CYCLES, default 4, number of clocks scoreToggle is held high per point (range 1..15).
REQ-002 SHALL have parameter PULSE_LOW_CYCLES, default 4, minimum clocks scoreToggle is held low between pulses (range 1..15).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port hit_valid  input  1  collision logic reports an asteroid hit this cycle.
REQ-006 SHALL have port hit_points  input  2  points awarded by the hit (0..3); sampled only when hit_valid=1.
REQ-007 SHALL have port clear_pending  input  1  synchronous discard of all queued points (game over or new game).
REQ-008 SHALL have port scoreToggle  output  1  registered, glitch-free score pulse; one rising edge per point, drives the score counter.
REQ-009 SHALL have port pending  output  4  queued points not yet emitted.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not IDLE or pending is non-zero.
REQ-011 SHALL have port overflow  output  1  sticky flag; points were lost to saturation.

Function
REQ-012 SHALL implement FSM states IDLE, HIGH and LOW.
REQ-013 IDLE: SHALL go to HIGH when pending>0 at the clock edge; otherwise SHALL remain in IDLE.
REQ-014 HIGH: SHALL drive scoreToggle=1 for exactly PULSE_HIGH_CYCLES clocks, then go to LOW.
REQ-015 LOW: SHALL drive scoreToggle=0 for exactly PULSE_LOW_CYCLES clocks, then go to HIGH if pending>0, else to IDLE.
REQ-016 Pending SHALL decrement by 1 on the edge that enters HIGH; each entry into HIGH corresponds to exactly one point.
REQ-017 On a hit with hit_points>0, pending SHALL increase by hit_points on the sampling edge; hit_points=0 SHALL be ignored.
REQ-018 Simultaneous hit and HIGH entry: pending SHALL become pending+hit_points-1, computed in 5 bits.
REQ-019 If the computed result exceeds 15, pending SHALL saturate at 15 and overflow SHALL be set; overflow SHALL clear only on reset.
REQ-020 clear_pending SHALL force pending to 0 on that edge and SHALL take priority over a same-cycle hit.
REQ-021 clear_pending SHALL NOT truncate a pulse in progress; HIGH and LOW SHALL complete their full counts, then the FSM SHALL go to IDLE.
REQ-022 Latency: a hit sampled at edge N SHALL raise scoreToggle after edge N+1 when the FSM is IDLE (two-edge latency).
REQ-023 scoreToggle SHALL come directly from a flip-flop with no combinational path from any input.
REQ-024 A width counter SHALL time HIGH and LOW; it SHALL reload on every state entry and SHALL never wrap.

Reset
REQ-025 When reset is low, the block SHALL immediately and asynchronously set state=IDLE, scoreToggle=0, pending=0, overflow=0, busy=0 and the width counter to 0.
REQ-026 Reset asserted mid-pulse SHALL drop scoreToggle to 0 at once; queued points SHALL be discarded.
REQ-027 After reset is released, the first hit SHALL follow REQ-022 timing exactly.

Structure
REQ-028 Shared package score_pkg SHALL hold the FSM state enum, PENDING_W=4, PENDING_MAX=15, the points width (2) and the default pulse widths.
REQ-029 The width counter SHALL be a sub-module pulse_width_timer with inputs load, load_value and tick and output done.
REQ-030 The total implementation SHALL fit in 120-400 lines of RTL.

Verification
REQ-031 Test: single hit of 1 point at edge 0 -> scoreToggle high from edge 2 through edge 5, low at edge 6, IDLE and busy=0 from edge 10.
REQ-032 Test: one hit of 3 points -> three pulses, each 4 clocks high and 4 clocks low; pending reads 3,2,1,0 across the pulses; exactly three rising edges.
REQ-033 Test: six back-to-back 3-point hits -> pending saturates at 15 and overflow=1; exactly 15 pulses follow, then the FSM is IDLE.
REQ-034 Test: clear_pending and a 2-point hit in the same cycle while in the 2nd HIGH clock -> the current pulse completes its 4 high clocks, pending=0, no further pulses.
REQ-035 Test: reset pulled low in the 3rd HIGH clock with pending=5 -> scoreToggle=0 and pending=0 immediately; no pulses after release until a new hit.
REQ-036 Test: a hit arriving on the edge that enters HIGH with pending=1 -> pending=hit_points, with no lost or duplicated points.

Source files
------------

// File: rtl/score_pkg.sv
// Shared definitions for the score pulse generator.
//   PENDING_W / PENDING_MAX : width and saturation limit of the queued-point counter
//   POINTS_W                : width of the per-hit point value
//   DEF_PULSE_HIGH/LOW      : default pulse high/low widths in clocks
//   CNT_W                   : width of the pulse width timer
//   state_e                 : pulse FSM states
package score_pkg;

  localparam int unsigned PENDING_W      = 4;
  localparam int unsigned PENDING_MAX    = 15;
  localparam int unsigned POINTS_W       = 2;
  localparam int unsigned DEF_PULSE_HIGH = 4;
  localparam int unsigned DEF_PULSE_LOW  = 4;
  localparam int unsigned CNT_W          = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } state_e;

endpackage

// File: rtl/score_pulse_gen_if.sv
// Hit / score bundle between collision logic (master) and the pulse generator (slave).
//   hit_valid, hit_points, clear_pending : master -> slave
//   scoreToggle, pending, busy, overflow : slave -> master
interface score_pulse_gen_if;
  import score_pkg::*;

  logic                 hit_valid;
  logic [POINTS_W-1:0]  hit_points;
  logic                 clear_pending;
  logic                 scoreToggle;
  logic [PENDING_W-1:0] pending;
  logic                 busy;
  logic                 overflow;

  modport master (
    output hit_valid,
    output hit_points,
    output clear_pending,
    input  scoreToggle,
    input  pending,
    input  busy,
    input  overflow
  );

  modport slave (
    input  hit_valid,
    input  hit_points,
    input  clear_pending,
    output scoreToggle,
    output pending,
    output busy,
    output overflow
  );

endinterface

// File: rtl/pulse_width_timer.sv
// Down-counter timing the HIGH and LOW phases of a score pulse.
//   clk, reset  : clock, asynchronous active-low reset
//   load        : reload the counter with load_value (state entry)
//   load_value  : phase length minus one
//   tick        : count down by one; holds at zero, never wraps
//   done        : counter is at zero (last clock of the phase)
module pulse_width_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             tick,
  output logic             done
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0);

endmodule

// File: rtl/score_pulse_gen.sv
// Converts asteroid hits into a train of score pulses, one rising edge of
// scoreToggle per point, with queued points counted in pending.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : score_pulse_gen_if slave (hits in; scoreToggle/pending/busy/overflow out)
module score_pulse_gen
  import score_pkg::*;
#(
  parameter int unsigned PULSE_HIGH_CYCLES = DEF_PULSE_HIGH,
  parameter int unsigned PULSE_LOW_CYCLES  = DEF_PULSE_LOW
) (
  input  logic              clk,
  input  logic              reset,
  score_pulse_gen_if.slave  bus
);

  state_e               r_state, w_state_d;
  logic [PENDING_W-1:0] r_pending, w_pending_d;
  logic                 r_overflow, w_overflow_d;
  logic                 r_toggle;

  logic                 w_done;
  logic                 w_load;
  logic [CNT_W-1:0]     w_load_value;
  logic                 w_tick;
  logic                 w_enter_high;
  logic [PENDING_W:0]   w_sum;
  logic [PENDING_W:0]   w_hit_add;

  pulse_width_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .load_value (w_load_value),
    .tick       (w_tick),
    .done       (w_done)
  );

  // Next-state; clear_pending never shortens a phase, it only empties the queue.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (r_pending != '0) w_state_d = StHigh;
      StHigh:  if (w_done) w_state_d = StLow;
      StLow:   if (w_done) w_state_d = (r_pending != '0) ? StHigh : StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_enter_high = (w_state_d == StHigh) && (r_state != StHigh);
    // Timer holds phase length minus one, so done marks the final clock.
    w_load       = (w_state_d != r_state) && (w_state_d != StIdle);
    w_load_value = (w_state_d == StHigh) ? CNT_W'(PULSE_HIGH_CYCLES - 1)
                                         : CNT_W'(PULSE_LOW_CYCLES - 1);
    w_tick       = (r_state != StIdle);
  end

  // Pending update in one extra bit so hit-plus-decrement can detect saturation.
  always_comb begin
    w_hit_add    = bus.hit_valid ? (PENDING_W+1)'(bus.hit_points) : '0;
    w_sum        = {1'b0, r_pending} + w_hit_add - (PENDING_W+1)'(w_enter_high);
    w_pending_d  = w_sum[PENDING_W-1:0];
    w_overflow_d = r_overflow;
    if (bus.clear_pending) begin
      w_pending_d = '0;
    end else if (w_sum > (PENDING_W+1)'(PENDING_MAX)) begin
      w_pending_d  = PENDING_W'(PENDING_MAX);
      w_overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_toggle   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pending  <= w_pending_d;
      r_overflow <= w_overflow_d;
      // Registered from next state so the output flop is high exactly while in HIGH.
      r_toggle   <= (w_state_d == StHigh);
    end
  end

  assign bus.scoreToggle = r_toggle;
  assign bus.pending     = r_pending;
  assign bus.busy        = (r_state != StIdle) || (r_pending != '0);
  assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_score_pulse_gen.sv
// Directed self-checking bench for score_pulse_gen (default 4/4 pulse widths).
// Edge numbering: edge 0 is the clock edge that samples the first hit.
module tb_score_pulse_gen;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   rises;

  score_pulse_gen_if dut_if ();

  score_pulse_gen #(
    .PULSE_HIGH_CYCLES (4),
    .PULSE_LOW_CYCLES  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge dut_if.scoreToggle) rises++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    rises = 0;
  endtask

  task automatic apply_hit(input logic [1:0] pts);
    dut_if.hit_valid  = 1'b1;
    dut_if.hit_points = pts;
    tick();
    dut_if.hit_valid  = 1'b0;
    dut_if.hit_points = 2'd0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (dut_if.busy && n < max_cycles) begin
      tick();
      n++;
    end
    check_eq("idle_reached", 32'(dut_if.busy), 0);
  endtask

  initial begin
    n_checks             = 0;
    n_errors             = 0;
    rises                = 0;
    reset                = 1'b0;
    dut_if.hit_valid     = 1'b0;
    dut_if.hit_points    = 2'd0;
    dut_if.clear_pending = 1'b0;
    #2;
    check_eq("rst_toggle", 32'(dut_if.scoreToggle), 0);
    check_eq("rst_pending", 32'(dut_if.pending), 0);
    check_eq("rst_busy", 32'(dut_if.busy), 0);
    check_eq("rst_overflow", 32'(dut_if.overflow), 0);
    do_reset();

    // Single 1-point hit: high at edges 2..5, low at 6, idle from 10.
    apply_hit(2'd1);
    check_eq("t1_pend_e0", 32'(dut_if.pending), 1);
    check_eq("t1_tog_e0", 32'(dut_if.scoreToggle), 0);
    tick();
    check_eq("t1_pend_e1", 32'(dut_if.pending), 0);
    for (int i = 1; i <= 4; i++) begin
      check_eq("t1_tog_high", 32'(dut_if.scoreToggle), 1);
      tick();
    end
    check_eq("t1_tog_low", 32'(dut_if.scoreToggle), 0);
    tick(); tick(); tick();
    check_eq("t1_busy_e8", 32'(dut_if.busy), 1);
    tick();
    check_eq("t1_busy_e9", 32'(dut_if.busy), 0);
    check_eq("t1_rises", 32'(rises), 1);

    // One 3-point hit: three 4-high/4-low pulses, pending 3,2,1,0.
    rises = 0;
    apply_hit(2'd3);
    check_eq("t2_pend_e0", 32'(dut_if.pending), 3);
    for (int i = 1; i <= 24; i++) begin
      tick();
      check_eq("t2_tog", 32'(dut_if.scoreToggle), (((i - 1) % 8) < 4) ? 1 : 0);
      check_eq("t2_pend", 32'(dut_if.pending), (i <= 8) ? 2 : (i <= 16) ? 1 : 0);
    end
    tick();
    check_eq("t2_busy_end", 32'(dut_if.busy), 0);
    check_eq("t2_rises", 32'(rises), 3);

    // Six back-to-back 3-point hits: 3,5,8,11,14,saturate at 15.
    rises = 0;
    dut_if.hit_valid  = 1'b1;
    dut_if.hit_points = 2'd3;
    for (int i = 0; i < 5; i++) tick();
    check_eq("t3_pend_e4", 32'(dut_if.pending), 14);
    check_eq("t3_ovf_e4", 32'(dut_if.overflow), 0);
    tick();
    dut_if.hit_valid  = 1'b0;
    dut_if.hit_points = 2'd0;
    check_eq("t3_pend_sat", 32'(dut_if.pending), 15);
    check_eq("t3_ovf", 32'(dut_if.overflow), 1);
    check_eq("t3_rises_pre", 32'(rises), 1);
    wait_idle(300);
    check_eq("t3_rises_after", 32'(rises), 16);
    check_eq("t3_ovf_sticky", 32'(dut_if.overflow), 1);
    do_reset();
    check_eq("t3_ovf_cleared", 32'(dut_if.overflow), 0);

    // clear_pending plus 2-point hit during the 2nd HIGH clock.
    apply_hit(2'd3);
    tick();
    check_eq("t4_tog_h1", 32'(dut_if.scoreToggle), 1);
    tick();
    dut_if.clear_pending = 1'b1;
    dut_if.hit_valid     = 1'b1;
    dut_if.hit_points    = 2'd2;
    tick();
    dut_if.clear_pending = 1'b0;
    dut_if.hit_valid     = 1'b0;
    dut_if.hit_points    = 2'd0;
    check_eq("t4_pend_clr", 32'(dut_if.pending), 0);
    check_eq("t4_tog_h3", 32'(dut_if.scoreToggle), 1);
    tick();
    check_eq("t4_tog_h4", 32'(dut_if.scoreToggle), 1);
    tick();
    check_eq("t4_tog_low", 32'(dut_if.scoreToggle), 0);
    wait_idle(50);
    for (int i = 0; i < 10; i++) tick();
    check_eq("t4_rises", 32'(rises), 1);

    // Reset in the 3rd HIGH clock with pending=5.
    rises = 0;
    apply_hit(2'd3);
    dut_if.hit_valid  = 1'b1;
    dut_if.hit_points = 2'd3;
    tick();
    dut_if.hit_valid  = 1'b0;
    dut_if.hit_points = 2'd0;
    check_eq("t5_pend5", 32'(dut_if.pending), 5);
    tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    check_eq("t5_tog_rst", 32'(dut_if.scoreToggle), 0);
    check_eq("t5_pend_rst", 32'(dut_if.pending), 0);
    check_eq("t5_busy_rst", 32'(dut_if.busy), 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check_eq("t5_rises_quiet", 32'(rises), 1);
    check_eq("t5_tog_quiet", 32'(dut_if.scoreToggle), 0);
    apply_hit(2'd1);
    check_eq("t5_tog_e0", 32'(dut_if.scoreToggle), 0);
    tick();
    check_eq("t5_tog_e1", 32'(dut_if.scoreToggle), 1);
    wait_idle(50);

    // Hit on the edge that enters HIGH with pending=1.
    rises = 0;
    apply_hit(2'd1);
    dut_if.hit_valid  = 1'b1;
    dut_if.hit_points = 2'd2;
    tick();
    dut_if.hit_valid  = 1'b0;
    dut_if.hit_points = 2'd0;
    check_eq("t6_pend", 32'(dut_if.pending), 2);
    check_eq("t6_tog", 32'(dut_if.scoreToggle), 1);
    wait_idle(100);
    check_eq("t6_rises", 32'(rises), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
